// File: rtl/pipelined_subtractor_64_pkg.sv
// sub_pkg: shared constants and types for the pipelined 64-bit subtractor.
//   WIDTH   - operand/result width
//   SLICE_W - bits subtracted per pipeline stage
//   STAGES  - pipeline depth (= latency in cycles)
//   CFG_OK  - true when WIDTH is exactly covered by the slices
package sub_pkg;

  localparam int unsigned WIDTH   = 64;
  localparam int unsigned SLICE_W = 16;
  localparam int unsigned STAGES  = 4;

  localparam bit CFG_OK = (WIDTH == SLICE_W * STAGES);

  typedef logic [WIDTH-1:0] word_t;

  // Per-stage pipeline register contents (valid bits are kept separately
  // in a shift register so bubbles cost only one flop per stage).
  typedef struct packed {
    logic  borrow;  // borrow-out of the slice this stage just computed
    word_t res;     // result bits produced so far; higher bits are zero
    word_t p_rem;   // minuend bits not yet consumed; consumed bits are zero
    word_t q_rem;   // subtrahend bits not yet consumed
  } stage_t;

  // Keeps only the bits at or above slice n; the bits below have already
  // been folded into the partial result and need not travel further.
  function automatic word_t upper_mask(int unsigned n);
    return {WIDTH{1'b1}} << (n * SLICE_W);
  endfunction

endpackage

// File: rtl/pipelined_subtractor_64_sub_slice.sv
// sub_slice: combinational W-bit subtract with borrow-in / borrow-out.
//   a, b  - slice operands (computes a - b - bin)
//   bin   - borrow from the next-lower slice
//   diff  - W-bit slice difference
//   bout  - borrow out of this slice (MSB of the W+1-bit difference)
module sub_slice
  import sub_pkg::*;
#(
  parameter int unsigned W = SLICE_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  // Zero-extending both operands by one bit makes the extra MSB go to 1
  // exactly when the true difference is negative, i.e. a borrow.
  logic [W:0] full;

  assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  assign diff = full[W-1:0];
  assign bout = full[W];

endmodule

// File: rtl/pipelined_subtractor_64.sv
// pipelined_subtractor_64: STAGES-deep pipelined unsigned subtractor, p - q.
// One SLICE_W-bit slice is resolved per stage, the borrow ripples through
// the stage registers.
//   clk, rst            - clock, synchronous active-high reset
//   p, q, in_valid      - operand request; in_ready = block accepts
//   result, borrow      - (p - q) mod 2^WIDTH, and p < q
//   out_valid/out_ready - result handshake with full backpressure
module pipelined_subtractor_64
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             out_valid,
  input  logic             out_ready
);

  if (!CFG_OK) begin : g_cfg_err
    $error("pipelined_subtractor_64: WIDTH must equal SLICE_W*STAGES");
  end

  // vld_pipe[k+1] is the valid bit of stage k; vld_pipe[STAGES] is out_valid.
  logic [STAGES:1]    vld_pipe;
  stage_t             stg_q  [STAGES];
  stage_t             stg_in [STAGES];
  stage_t             stg_d  [STAGES];
  logic [SLICE_W-1:0] dif    [STAGES];
  logic               bout   [STAGES];
  logic               stall;
  logic               accept;

  // A result is held at the output until taken; since there is no skid
  // buffer the whole pipeline freezes with it, and the input stalls
  // combinationally in the same cycle.
  assign stall    = vld_pipe[STAGES] & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Stage inputs: stage 0 sees the raw operands with borrow-in 0,
  // every later stage sees the register of the stage before it.
  always_comb begin
    stg_in[0].borrow = 1'b0;
    stg_in[0].res    = '0;
    stg_in[0].p_rem  = p;
    stg_in[0].q_rem  = q;
    for (int k = 1; k < STAGES; k++) begin
      stg_in[k] = stg_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sub_slice #(.W(SLICE_W)) u_slice (
      .a    (stg_in[k].p_rem[k*SLICE_W +: SLICE_W]),
      .b    (stg_in[k].q_rem[k*SLICE_W +: SLICE_W]),
      .bin  (stg_in[k].borrow),
      .diff (dif[k]),
      .bout (bout[k])
    );
  end

  // Next-state of each stage: slice k is ORed into the partial result
  // (its bits are still zero there), and the consumed operand bits are
  // cleared so only the untouched upper bits move on.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      stg_d[k].borrow = bout[k];
      stg_d[k].res    = stg_in[k].res | (word_t'(dif[k]) << (k * SLICE_W));
      stg_d[k].p_rem  = stg_in[k].p_rem & upper_mask(k + 1);
      stg_d[k].q_rem  = stg_in[k].q_rem & upper_mask(k + 1);
    end
  end

  // Data registers load on every unstalled edge, bubbles included; the
  // valid bits decide whether what comes out means anything.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= '0;
      end
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      for (int k = 0; k < STAGES; k++) begin
        stg_q[k] <= stg_d[k];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign result    = stg_q[STAGES-1].res;
  assign borrow    = stg_q[STAGES-1].borrow;

endmodule

// File: tb/tb_pipelined_subtractor_64.sv
// Self-checking bench for pipelined_subtractor_64. A queue model (one entry
// per accepted op, aged by unstalled edges) is compared against the DUT on
// every cycle; directed ops pin the model with literal expectations.
module tb_pipelined_subtractor_64;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] p, q, result;
  logic        in_valid, in_ready, borrow, out_valid, out_ready;

  always #5 clk = ~clk;

  pipelined_subtractor_64 dut (
    .clk       (clk),
    .rst       (rst),
    .p         (p),
    .q         (q),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .borrow    (borrow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(3))
      0:       return 64'($urandom_range(255));
      1:       return {$urandom, 32'h0};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Each accepted op becomes (p-q, p<q) with an age equal to the number of
  // unstalled edges it has seen. The oldest op is visible once it has passed
  // through all 4 stages (age 4) and stays there until taken.
  typedef struct {
    logic [63:0] r;
    logic        b;
    int          age;
  } ent_t;

  ent_t mq[$];
  bit   armed  = 1'b0;
  int   n_acc  = 0;
  int   n_pop  = 0;
  int   n_drop = 0;

  always @(negedge clk) begin
    bit   mv;
    bit   mstall;
    ent_t e;
    mv     = (mq.size() > 0) && (mq[0].age >= 4);
    mstall = mv && !out_ready;
    if (armed) begin
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("in_ready", 64'(in_ready), 64'(!mstall));
      if (mv) begin
        chk("result", result, mq[0].r);
        chk("borrow", 64'(borrow), 64'(mq[0].b));
      end
    end
    if (rst) begin
      n_drop += mq.size();
      mq.delete();
      armed = 1'b1;
    end else if (armed && !mstall) begin
      if (mv) begin
        void'(mq.pop_front());
        n_pop++;
      end
      foreach (mq[i]) mq[i].age++;
      if (in_valid) begin
        e.r   = p - q;
        e.b   = (p < q);
        e.age = 1;
        mq.push_back(e);
        n_acc++;
      end
    end
  end

  // ---------------- directed single op ----------------
  task automatic run_one(input string nm, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] er, input logic eb);
    int n;
    @(posedge clk); #1;
    p = a; q = b; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) in_valid = 1'b0;
      if (out_valid) break;
    end
    chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_result"}, result, er);
    chk({nm, "_borrow"}, 64'(borrow), 64'(eb));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first, last;
    bit pend;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; p = '0; q = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", result, 64'd0);
    chk("rst_borrow", 64'(borrow), 64'd0);

    // directed ops with hand-computed results
    run_one("simple", 64'h10, 64'h3, 64'hD, 1'b0);
    run_one("xslice", 64'h0000_0001_0000_0000, 64'h1, 64'h0000_0000_FFFF_FFFF, 1'b0);
    run_one("wrap", 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_one("equal", 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 64'h0, 1'b0);
    run_one("msb", 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);

    // back-to-back stream of 8 with out_ready held high
    cnt = 0; first = -1; last = -1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        p = rnd64(); q = ($urandom_range(5) == 0) ? p : rnd64(); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    chk("stream_count", 64'(cnt), 64'd8);
    chk("stream_contiguous", 64'(last - first), 64'd7);

    // backpressure: three ops pending, output blocked
    out_ready = 1'b0;
    p = 64'h50;   q = 64'h10; in_valid = 1'b1; @(posedge clk); #1;
    p = 64'h1000; q = 64'h1;                   @(posedge clk); #1;
    p = 64'h5;    q = 64'h7;                   @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("bp_arrived", 64'(out_valid), 64'd1);
    // offer a new op while stalled; it must wait, unchanged, for in_ready
    p = 64'h9; q = 64'h2; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_result", result, 64'h40);
      chk("bp_hold_borrow", 64'(borrow), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);

    // mid-flight reset: nothing accepted before it may come out
    #1;
    p = 64'h111; q = 64'h11; in_valid = 1'b1; @(posedge clk); #1;
    p = 64'h222; q = 64'h22;                  @(posedge clk); #1;
    p = 64'h333; q = 64'h33; rst = 1'b1;      @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_result", result, 64'd0);
    chk("mrst_borrow", 64'(borrow), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("mrst_no_ghost", 64'(cnt), 64'd0);

    // random traffic with random backpressure; operands held until accepted
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!pend) begin
        if ($urandom_range(3) != 0) begin
          p = rnd64(); q = ($urandom_range(7) == 0) ? p : rnd64();
          in_valid = 1'b1; pend = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) pend = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);

    chk("drained", 64'(mq.size()), 64'd0);
    chk("conservation", 64'(n_acc), 64'(n_pop + n_drop));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
